// File: rtl/cordic_iter_unit.sv
// cordic_iter_unit: iterative CORDIC engine, one micro-rotation per clock.
// Supports rotation (drive Z to 0) and vectoring (drive Y to 0) modes.
// Quadrant pre-rotation at accept extends coverage to the full circle.
// Optional gain correction by K is applied, then X/Y/Z saturate to N bits.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE.
// out_valid rises when a result is registered and holds, with xo/yo/zo/ovf stable, until out_ready.
module cordic_iter_unit #(
  parameter int N         = 32,
  parameter int FRAC      = 28,
  parameter int ITER      = 16,
  parameter int GAIN_CORR = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         rot_vec,
  input  logic [N-1:0] xi,
  input  logic [N-1:0] yi,
  input  logic [N-1:0] zi,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] xo,
  output logic [N-1:0] yo,
  output logic [N-1:0] zo,
  output logic         ovf
);

  // Constants are tabulated at 28 fractional bits and rescaled to FRAC.
  localparam int UP = (FRAC >= 28) ? FRAC - 28 : 0;
  localparam int DN = (FRAC < 28) ? 28 - FRAC : 0;

  localparam logic [63:0] HALF_PI_W = (64'd421657428 << UP) >> DN;
  localparam logic [63:0] K_W       = (64'd163008218 << UP) >> DN;

  localparam logic signed [N:0]       HALF_PI = (N+1)'(HALF_PI_W);
  localparam logic signed [2*N+3:0]   K_EXT   = (2*N+4)'(K_W);
  localparam logic [4:0]              LAST    = 5'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_CORR = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;

  logic signed [N+1:0] x_r, y_r;
  logic signed [N:0]   z_r;
  logic                mode_r;
  logic [4:0]          cnt;

  // atan(2^-i) in radians, 28 fractional bits, rescaled to FRAC.
  function automatic logic signed [N:0] atan_val(input logic [4:0] idx);
    logic [63:0] t;
    case (idx)
      5'd0:  t = 64'd210828714;
      5'd1:  t = 64'd124459457;
      5'd2:  t = 64'd65760959;
      5'd3:  t = 64'd33381290;
      5'd4:  t = 64'd16755422;
      5'd5:  t = 64'd8385879;
      5'd6:  t = 64'd4193963;
      5'd7:  t = 64'd2097109;
      5'd8:  t = 64'd1048571;
      5'd9:  t = 64'd524287;
      5'd10: t = 64'd262144;
      5'd11: t = 64'd131072;
      5'd12: t = 64'd65536;
      5'd13: t = 64'd32768;
      5'd14: t = 64'd16384;
      5'd15: t = 64'd8192;
      5'd16: t = 64'd4096;
      5'd17: t = 64'd2048;
      5'd18: t = 64'd1024;
      5'd19: t = 64'd512;
      5'd20: t = 64'd256;
      5'd21: t = 64'd128;
      5'd22: t = 64'd64;
      5'd23: t = 64'd32;
      5'd24: t = 64'd16;
      5'd25: t = 64'd8;
      5'd26: t = 64'd4;
      5'd27: t = 64'd2;
      default: t = 64'd0;
    endcase
    return (N+1)'((t << UP) >> DN);
  endfunction

  // Clamp a wide value to N bits; the top bit of the return is the saturation flag.
  function automatic logic [N:0] sat(input logic signed [2*N+3:0] v);
    logic [N+4:0] hi;
    hi = v[2*N+3:N-1];
    if (hi == '0 || hi == '1) return {1'b0, v[N-1:0]};
    else                      return {1'b1, v[2*N+3], {(N-1){~v[2*N+3]}}};
  endfunction

  // Quadrant pre-rotation of the incoming operands.
  logic signed [N+1:0] xi_e, yi_e, x0, y0;
  logic signed [N:0]   zi_e, z0;
  always_comb begin
    xi_e = {{2{xi[N-1]}}, xi};
    yi_e = {{2{yi[N-1]}}, yi};
    zi_e = {zi[N-1], zi};
    x0   = xi_e;
    y0   = yi_e;
    z0   = zi_e;
    if (!rot_vec) begin
      if (zi_e > HALF_PI) begin
        x0 = -yi_e;
        y0 = xi_e;
        z0 = zi_e - HALF_PI;
      end else if (zi_e < -HALF_PI) begin
        x0 = yi_e;
        y0 = -xi_e;
        z0 = zi_e + HALF_PI;
      end
    end else if (xi_e[N+1]) begin
      if (!yi_e[N+1]) begin
        x0 = yi_e;
        y0 = -xi_e;
        z0 = zi_e + HALF_PI;
      end else begin
        x0 = -yi_e;
        y0 = xi_e;
        z0 = zi_e - HALF_PI;
      end
    end
  end

  // One micro-rotation step on the current state.
  logic                d_pos;
  logic signed [N+1:0] xs, ys, x_n, y_n;
  logic signed [N:0]   at, z_n;
  always_comb begin
    d_pos = mode_r ? y_r[N+1] : ~z_r[N];
    xs    = x_r >>> cnt;
    ys    = y_r >>> cnt;
    at    = atan_val(cnt);
    if (d_pos) begin
      x_n = x_r - ys;
      y_n = y_r + xs;
      z_n = z_r - at;
    end else begin
      x_n = x_r + ys;
      y_n = y_r - xs;
      z_n = z_r + at;
    end
  end

  // Gain correction (floor of the full product) followed by saturation.
  logic signed [2*N+3:0] x_ext, y_ext, z_ext, x_w, y_w;
  logic [N:0]            x_s, y_s, z_s;
  always_comb begin
    x_ext = {{(N+2){x_r[N+1]}}, x_r};
    y_ext = {{(N+2){y_r[N+1]}}, y_r};
    z_ext = {{(N+3){z_r[N]}}, z_r};
    if (GAIN_CORR != 0) begin
      x_w = (x_ext * K_EXT) >>> FRAC;
      y_w = (y_ext * K_EXT) >>> FRAC;
    end else begin
      x_w = x_ext;
      y_w = y_ext;
    end
    x_s = sat(x_w);
    y_s = sat(y_w);
    z_s = sat(z_ext);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      xo        <= '0;
      yo        <= '0;
      zo        <= '0;
      ovf       <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      mode_r    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            x_r      <= x0;
            y_r      <= y0;
            z_r      <= z0;
            mode_r   <= rot_vec;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_ITER;
          end
        end
        S_ITER: begin
          x_r <= x_n;
          y_r <= y_n;
          z_r <= z_n;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) state <= S_CORR;
        end
        S_CORR: begin
          xo        <= x_s[N-1:0];
          yo        <= y_s[N-1:0];
          zo        <= z_s[N-1:0];
          ovf       <= x_s[N] | y_s[N] | z_s[N];
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_unit.sv
// tb_cordic_iter_unit: directed vectors against hand-computed CORDIC results.
// u0 uses gain correction; u1 runs without it for the saturation case.
module tb_cordic_iter_unit;

  localparam int TOL = 65536;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, rot_vec, out_ready, sel;
  logic [31:0] xi, yi, zi;

  logic        in_valid0, in_ready0, out_valid0, ovf0;
  logic [31:0] xo0, yo0, zo0;
  logic        in_valid1, in_ready1, out_valid1, ovf1;
  logic [31:0] xo1, yo1, zo1;

  assign in_valid0 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  cordic_iter_unit #(.N(32), .FRAC(28), .ITER(16), .GAIN_CORR(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .rot_vec(rot_vec), .xi(xi), .yi(yi), .zi(zi),
    .out_valid(out_valid0), .out_ready(out_ready),
    .xo(xo0), .yo(yo0), .zo(zo0), .ovf(ovf0)
  );

  cordic_iter_unit #(.N(32), .FRAC(28), .ITER(16), .GAIN_CORR(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .rot_vec(rot_vec), .xi(xi), .yi(yi), .zi(zi),
    .out_valid(out_valid1), .out_ready(out_ready),
    .xo(xo1), .yo(yo1), .zo(zo1), .ovf(ovf1)
  );

  // Observed view of whichever unit is selected.
  logic        ir, ov, of;
  logic [31:0] ox, oy, oz;
  assign ir = sel ? in_ready1  : in_ready0;
  assign ov = sel ? out_valid1 : out_valid0;
  assign of = sel ? ovf1       : ovf0;
  assign ox = sel ? xo1        : xo0;
  assign oy = sel ? yo1        : yo0;
  assign oz = sel ? zo1        : zo0;

  // Scoreboard counters and the single checker.
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
    longint diff;
    total++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Present one operation, wait for the result; lat counts the accepting edge as edge 1.
  task automatic start_op(input logic s, input logic m, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, output int lat);
    int n;
    @(negedge clk);
    sel = s; rot_vec = m; xi = x; yi = y; zi = z;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", longint'(ir), 1, 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!ov && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("out_valid_seen", longint'(ov), 1, 0);
  endtask

  // Complete the output handshake and check the return to IDLE.
  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, longint'(ov), 0, 0);
    chk({tag, "_ir_high"}, longint'(ir), 1, 0);
  endtask

  // Main directed sequence.
  initial begin
    int lat, first, second, n;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; rot_vec = 1'b0; out_ready = 1'b0; sel = 1'b0;
    xi = '0; yi = '0; zi = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready0), 1, 0);
    chk("rst_out_valid", longint'(out_valid0), 0, 0);
    chk("rst_xo", longint'(xo0), 0, 0);
    chk("rst_yo", longint'(yo0), 0, 0);
    chk("rst_zo", longint'(zo0), 0, 0);
    chk("rst_ovf", longint'(ovf0), 0, 0);
    rst_n = 1'b1;

    // Rotation by pi/6 from (1,0).
    start_op(1'b0, 1'b0, 32'd268435456, 32'd0, 32'd140552476, lat);
    chk("rot_lat", lat, 18, 0);
    chk("rot_xo", longint'($signed(ox)), 232471925, TOL);
    chk("rot_yo", longint'($signed(oy)), 134217728, TOL);
    chk("rot_zo", longint'($signed(oz)), 0, TOL);
    chk("rot_ovf", longint'(of), 0, 0);

    // Backpressure: hold the result, ignore a new request.
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        in_valid = 1'b1; xi = 32'd0; yi = 32'd268435456; zi = 32'd0;
      end
      if (k == 4) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_ov", longint'(ov), 1, 0);
      chk("bp_ir", longint'(ir), 0, 0);
      chk("bp_xo", longint'($signed(ox)), 232471925, TOL);
      chk("bp_yo", longint'($signed(oy)), 134217728, TOL);
    end
    in_valid = 1'b0;
    finish_op("bp");
    chk("hold_xo", longint'($signed(ox)), 232471925, TOL);
    chk("hold_yo", longint'($signed(oy)), 134217728, TOL);
    repeat (3) @(negedge clk);
    chk("no_stray_result", longint'(ov), 0, 0);
    chk("idle_after_bp", longint'(ir), 1, 0);

    // Vectoring (3,4) -> magnitude 5, angle atan(4/3).
    start_op(1'b0, 1'b1, 32'd805306368, 32'd1073741824, 32'd0, lat);
    chk("vec_xo", longint'($signed(ox)), 1342177280, TOL);
    chk("vec_yo", longint'($signed(oy)), 0, TOL);
    chk("vec_zo", longint'($signed(oz)), 248918914, TOL);
    chk("vec_ovf", longint'(of), 0, 0);
    finish_op("vec");

    // Rotation by 3pi/4 exercises pre-rotation.
    start_op(1'b0, 1'b0, 32'd268435456, 32'd0, 32'd632486142, lat);
    chk("prerot_xo", longint'($signed(ox)), -189812531, TOL);
    chk("prerot_yo", longint'($signed(oy)), 189812531, TOL);
    chk("prerot_zo", longint'($signed(oz)), 0, TOL);
    finish_op("prerot");

    // Vectoring (-1,1) -> sqrt(2), 3pi/4.
    start_op(1'b0, 1'b1, 32'hF000_0000, 32'd268435456, 32'd0, lat);
    chk("prevec_xo", longint'($signed(ox)), 379625062, TOL);
    chk("prevec_yo", longint'($signed(oy)), 0, TOL);
    chk("prevec_zo", longint'($signed(oz)), 632486142, TOL);
    finish_op("prevec");

    // Back-to-back throughput with producer and consumer always ready.
    @(negedge clk);
    sel = 1'b0; rot_vec = 1'b0;
    xi = 32'd268435456; yi = 32'd0; zi = 32'd140552476;
    in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 80 && second < 0; c++) begin
      if (ir) begin
        if (first < 0) first = c;
        else           second = c;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_spacing", second - first, 19, 0);
    n = 0;
    while (!ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_valid", longint'(ov), 1, 0);
    chk("b2b_xo", longint'($signed(ox)), 232471925, TOL);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_ov_low", longint'(ov), 0, 0);

    // Saturation without gain correction: |(7.5,7.5)| * 1.6468 > 8.
    start_op(1'b1, 1'b1, 32'd2013265920, 32'd2013265920, 32'd0, lat);
    chk("sat_lat", lat, 18, 0);
    chk("sat_xo", longint'($signed(ox)), 2147483647, 0);
    chk("sat_ovf", longint'(of), 1, 0);
    chk("sat_zo", longint'($signed(oz)), 210828714, TOL);
    finish_op("sat");

    // Asynchronous reset in the middle of ITER.
    @(negedge clk);
    sel = 1'b0; rot_vec = 1'b0;
    xi = 32'd268435456; yi = 32'd0; zi = 32'd140552476;
    in_valid = 1'b1;
    chk("mid_accept_ready", longint'(in_ready0), 1, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", longint'(out_valid0), 0, 0);
    chk("mid_rst_ir", longint'(in_ready0), 1, 0);
    chk("mid_rst_xo", longint'(xo0), 0, 0);
    chk("mid_rst_yo", longint'(yo0), 0, 0);
    chk("mid_rst_zo", longint'(zo0), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid0) seen = 1'b1;
    end
    chk("mid_no_partial", longint'(seen), 0, 0);

    start_op(1'b0, 1'b0, 32'd268435456, 32'd0, 32'd140552476, lat);
    chk("post_rst_lat", lat, 18, 0);
    chk("post_rst_xo", longint'($signed(ox)), 232471925, TOL);
    chk("post_rst_yo", longint'($signed(oy)), 134217728, TOL);
    chk("post_rst_ovf", longint'(of), 0, 0);
    finish_op("post_rst");

    // Final report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
